// File: rtl/rv32imf_cg_pkg.sv
// Clock-gate controller shared types and default sizing.
// Used by rv32imf_clock_gate_ch and rv32imf_clock_gate_ctrl.
package rv32imf_cg_pkg;

  localparam int CG_NUM_CH_DEF = 4;
  localparam int CG_HOLD_W_DEF = 4;
  localparam int CG_STAT_W_DEF = 16;

  typedef enum logic [1:0] {
    CG_ON    = 2'd0,
    CG_DRAIN = 2'd1,
    CG_OFF   = 2'd2
  } cg_state_e;

endpackage

// File: rtl/rv32imf_clock_gate_ch.sv
// One gated clock channel: idle hysteresis FSM, ICG latch and AND.
// Gated-cycle statistics counter built only with RV32IMF_CG_STATS_EN.
module rv32imf_clock_gate_ch
  import rv32imf_cg_pkg::*;
#(
  parameter int HOLD_W = CG_HOLD_W_DEF,
  parameter int STAT_W = CG_STAT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              scan_cg_en_i,
  input  logic              wake_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  input  logic              stat_clr_i,
  output logic              clk_o,
  output logic              gated_o,
  output logic [STAT_W-1:0] gated_cnt_o
);

  cg_state_e         state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              gated_q;
  logic              en;
  logic              en_l;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CG_ON;
      cnt_q   <= '0;
      gated_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gated_q <= (state_q == CG_OFF);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CG_ON: begin
        if (!wake_i) begin
          if (hold_cycles_i == '0) begin
            state_d = CG_OFF;
          end else begin
            cnt_d   = hold_cycles_i - 1'b1;
            state_d = CG_DRAIN;
          end
        end
      end
      CG_DRAIN: begin
        if (wake_i) begin
          state_d = CG_ON;
        end else if (cnt_q == '0) begin
          state_d = CG_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CG_OFF: begin
        if (wake_i) state_d = CG_ON;
      end
      default: state_d = CG_ON;
    endcase
  end

  // wake bypasses the FSM so an OFF channel gets a pulse in the wake cycle
  always_comb begin
    en = (state_q != CG_OFF) | wake_i | scan_cg_en_i;
  end

  always_latch begin
    if (!clk_i) en_l = en;
  end

  assign clk_o   = clk_i & en_l;
  assign gated_o = gated_q;

`ifdef RV32IMF_CG_STATS_EN
  logic [STAT_W-1:0] stat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_q <= '0;
    end else if (stat_clr_i) begin
      stat_q <= '0;
    end else if (gated_q && !(&stat_q)) begin
      stat_q <= stat_q + 1'b1;
    end
  end

  assign gated_cnt_o = stat_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign gated_cnt_o     = '0;
`endif

endmodule

// File: rtl/rv32imf_clock_gate_ctrl.sv
// Multi-channel clock-gate controller with global sleep handshake.
// Optional per-channel gated-cycle counters: RV32IMF_CG_STATS_EN.
module rv32imf_clock_gate_ctrl
  import rv32imf_cg_pkg::*;
#(
  parameter int NUM_CH = CG_NUM_CH_DEF,
  parameter int HOLD_W = CG_HOLD_W_DEF,
  parameter int STAT_W = CG_STAT_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     scan_cg_en_i,
  input  logic [NUM_CH-1:0]        busy_i,
  input  logic [NUM_CH-1:0]        force_on_i,
  input  logic [HOLD_W-1:0]        hold_cycles_i,
  input  logic                     sleep_req_i,
  output logic                     sleep_ack_o,
  output logic [NUM_CH-1:0]        clk_o,
  output logic [NUM_CH-1:0]        ch_gated_o,
  output logic [NUM_CH*STAT_W-1:0] gated_cnt_o,
  input  logic                     stat_clr_i
);

  logic [NUM_CH-1:0] wake;
  logic [NUM_CH-1:0] gated;
  logic              ack_q;

  assign wake = busy_i | force_on_i;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    rv32imf_clock_gate_ch #(
      .HOLD_W(HOLD_W),
      .STAT_W(STAT_W)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .scan_cg_en_i (scan_cg_en_i),
      .wake_i       (wake[k]),
      .hold_cycles_i(hold_cycles_i),
      .stat_clr_i   (stat_clr_i),
      .clk_o        (clk_o[k]),
      .gated_o      (gated[k]),
      .gated_cnt_o  (gated_cnt_o[k*STAT_W +: STAT_W])
    );
  end

  // any pending wake drops the ack at once; the wake itself is never blocked
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ack_q <= 1'b0;
    else         ack_q <= sleep_req_i & (&gated) & ~(|wake);
  end

  assign sleep_ack_o = ack_q;
  assign ch_gated_o  = gated;

endmodule

// File: tb/tb_rv32imf_clock_gate_ctrl.sv
// Self-checking bench for rv32imf_clock_gate_ctrl.
// Reference model tracks idle-run lengths per channel.
module tb_rv32imf_clock_gate_ctrl;

  localparam int N  = 4;
  localparam int HW = 4;
  localparam int SW = 16;

  logic          clk;
  logic          rst_n;
  logic          scan;
  logic [N-1:0]  busy;
  logic [N-1:0]  force_on;
  logic [HW-1:0] hold;
  logic          sleep_req;
  logic          sleep_ack;
  logic [N-1:0]  clk_g;
  logic [N-1:0]  gated;
  logic [N*SW-1:0] cnt;
  logic          stat_clr;

  rv32imf_clock_gate_ctrl #(
    .NUM_CH(N), .HOLD_W(HW), .STAT_W(SW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .scan_cg_en_i (scan),
    .busy_i       (busy),
    .force_on_i   (force_on),
    .hold_cycles_i(hold),
    .sleep_req_i  (sleep_req),
    .sleep_ack_o  (sleep_ack),
    .clk_o        (clk_g),
    .ch_gated_o   (gated),
    .gated_cnt_o  (cnt),
    .stat_clr_i   (stat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // model: idle edges since last wake, hold snapshot at idle start
  int          idle [N];
  int          snap [N];
  logic [N-1:0] m_off;
  logic [N-1:0] m_gated;
  logic        m_ack;
  logic [15:0] m_cnt [N];
  logic [N-1:0] exp_clk;
  logic [N-1:0] seen_clk;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      idle[k]  = 0;
      snap[k]  = 0;
      m_cnt[k] = '0;
    end
    m_off   = '0;
    m_gated = '0;
    m_ack   = 1'b0;
  endtask

  task automatic tick();
    logic [N-1:0] wake;
    logic         nack;
    wake = busy | force_on;
    for (int k = 0; k < N; k++)
      exp_clk[k] = !m_off[k] | wake[k] | scan;
    @(posedge clk);
    #1;
    seen_clk = clk_g;
    nack = sleep_req & (&m_gated) & ~(|wake);
    for (int k = 0; k < N; k++) begin
      if (stat_clr) m_cnt[k] = '0;
      else if (m_gated[k] && m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 1;
    end
    m_gated = m_off;
    for (int k = 0; k < N; k++) begin
      if (wake[k]) begin
        idle[k] = 0;
      end else begin
        if (idle[k] < 1000) idle[k] = idle[k] + 1;
        if (idle[k] == 1) snap[k] = int'(hold);
      end
      m_off[k] = !wake[k] && (idle[k] >= snap[k] + 1);
    end
    m_ack = nack;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan = 0; busy = '0; force_on = '0;
    hold = 4'd3; sleep_req = 0; stat_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (clk_g !== 4'hF) $display("FAIL reset_clk got=%h exp=%h", clk_g, 4'hF);
    else n_pass++;
    n_total++;
    if (gated !== 4'h0) $display("FAIL reset_gated got=%h exp=0", gated);
    else n_pass++;
    n_total++;
    if (sleep_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", sleep_ack);
    else n_pass++;
    n_total++;
    if (cnt !== '0) $display("FAIL reset_cnt got=%h exp=0", cnt);
    else n_pass++;
  endtask

  task automatic test_reset_release();
    int pulses;
    rst_n = 1'b1;
    model_reset();
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      pulses += int'(seen_clk[0]);
      if (i == 4) begin
        n_total++;
        if (gated[0] !== 1'b0) $display("FAIL rel_gated_e4 got=%b exp=0", gated[0]);
        else n_pass++;
      end
      if (i == 5) begin
        n_total++;
        if (gated[0] !== 1'b1) $display("FAIL rel_gated_e5 got=%b exp=1", gated[0]);
        else n_pass++;
      end
    end
    n_total++;
    if (pulses != 4) $display("FAIL rel_pulses got=%0d exp=4", pulses);
    else n_pass++;
  endtask

  task automatic test_wake_pulse();
    int j;
    busy = 4'b0010;
    tick();
    busy = '0;
    n_total++;
    if (seen_clk[1] !== 1'b1) $display("FAIL wake_same_cycle got=%b exp=1", seen_clk[1]);
    else n_pass++;
    n_total++;
    if (seen_clk[0] !== 1'b0) $display("FAIL wake_other_ch got=%b exp=0", seen_clk[0]);
    else n_pass++;
    j = 0;
    for (int i = 1; i <= 20 && j == 0; i++) begin
      tick();
      if (i == 1) begin
        n_total++;
        if (gated[1] !== 1'b0) $display("FAIL wake_gated_drop got=%b exp=0", gated[1]);
        else n_pass++;
      end
      if (gated[1] === 1'b1) j = i;
    end
    n_total++;
    if (j != 5) $display("FAIL wake_regate got=%0d exp=5", j);
    else n_pass++;
  endtask

  task automatic test_hold_zero_and_restart();
    int j;
    hold = 4'd0;
    busy = 4'b0100;
    tick();
    busy = '0;
    tick();
    n_total++;
    if (gated[2] !== 1'b0 || seen_clk[2] !== 1'b1)
      $display("FAIL hold0_e1 got=%b%b exp=01", gated[2], seen_clk[2]);
    else n_pass++;
    tick();
    n_total++;
    if (gated[2] !== 1'b1 || seen_clk[2] !== 1'b0)
      $display("FAIL hold0_e2 got=%b%b exp=10", gated[2], seen_clk[2]);
    else n_pass++;
    hold = 4'd8;
    busy = 4'b0100;
    tick();
    busy = '0;
    repeat (3) tick();
    busy = 4'b0100;
    tick();
    n_total++;
    if (gated[2] !== 1'b0) $display("FAIL drain_rewake got=%b exp=0", gated[2]);
    else n_pass++;
    busy = '0;
    j = 0;
    for (int i = 1; i <= 30 && j == 0; i++) begin
      tick();
      if (i == 1) hold = 4'd2;
      if (gated[2] === 1'b1) j = i;
    end
    n_total++;
    if (j != 10) $display("FAIL drain_restart got=%0d exp=10", j);
    else n_pass++;
  endtask

  task automatic test_sleep();
    int t;
    hold = 4'd2;
    sleep_req = 1'b1;
    busy = 4'hF;
    tick();
    busy = '0;
    t = 0;
    for (int i = 1; i <= 12 && t == 0; i++) begin
      tick();
      if (&gated) begin
        t = i;
        n_total++;
        if (sleep_ack !== 1'b0) $display("FAIL sleep_ack_early got=%b exp=0", sleep_ack);
        else n_pass++;
      end
    end
    n_total++;
    if (t != 4) $display("FAIL sleep_all_gated got=%0d exp=4", t);
    else n_pass++;
    tick();
    n_total++;
    if (sleep_ack !== 1'b1) $display("FAIL sleep_ack got=%b exp=1", sleep_ack);
    else n_pass++;
    busy = 4'b0100;
    tick();
    n_total++;
    if (sleep_ack !== 1'b0 || seen_clk[2] !== 1'b1)
      $display("FAIL sleep_wake got=%b%b exp=01", sleep_ack, seen_clk[2]);
    else n_pass++;
    busy = '0;
    sleep_req = 1'b0;
  endtask

  task automatic test_scan();
    repeat (6) tick();
    scan = 1'b1;
    repeat (3) begin
      tick();
      n_total++;
      if (seen_clk !== 4'hF || gated !== 4'hF)
        $display("FAIL scan_on clk=%h gated=%h exp=F/F", seen_clk, gated);
      else n_pass++;
    end
    scan = 1'b0;
    tick();
    n_total++;
    if (seen_clk !== 4'h0) $display("FAIL scan_off got=%h exp=0", seen_clk);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        busy[k]     = ($urandom_range(0, 3) == 0);
        force_on[k] = ($urandom_range(0, 15) == 0);
      end
      if (c % 25 == 0) hold = HW'($urandom_range(0, 5));
      if (c % 10 == 0) sleep_req = 1'($urandom_range(0, 1));
      if (c % 7 == 0) busy = '0;
      scan     = ($urandom_range(0, 19) == 0);
      stat_clr = ($urandom_range(0, 63) == 0);
      tick();
      n_total++;
      if (seen_clk !== exp_clk)
        $display("FAIL rnd_clk c=%0d got=%h exp=%h", c, seen_clk, exp_clk);
      else n_pass++;
      n_total++;
      if (gated !== m_gated)
        $display("FAIL rnd_gated c=%0d got=%h exp=%h", c, gated, m_gated);
      else n_pass++;
      n_total++;
      if (sleep_ack !== m_ack)
        $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, sleep_ack, m_ack);
      else n_pass++;
`ifdef RV32IMF_CG_STATS_EN
      for (int k = 0; k < N; k++) begin
        n_total++;
        if (cnt[k*SW +: SW] !== m_cnt[k])
          $display("FAIL rnd_cnt c=%0d ch=%0d got=%h exp=%h", c, k, cnt[k*SW +: SW], m_cnt[k]);
        else n_pass++;
      end
`endif
    end
    busy = '0; force_on = '0; scan = 0; stat_clr = 0; sleep_req = 0;
  endtask

`ifdef RV32IMF_CG_STATS_EN
  task automatic test_stats();
    hold = 4'd1;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    repeat (70000) tick();
    n_total++;
    if (cnt[15:0] !== 16'hFFFF || m_cnt[0] !== 16'hFFFF)
      $display("FAIL stat_sat got=%h exp=ffff", cnt[15:0]);
    else n_pass++;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_total++;
    if (cnt[15:0] !== 16'h0) $display("FAIL stat_clr got=%h exp=0", cnt[15:0]);
    else n_pass++;
    tick();
    n_total++;
    if (cnt[15:0] !== 16'h1) $display("FAIL stat_inc got=%h exp=1", cnt[15:0]);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_release();
    test_wake_pulse();
    test_hold_zero_and_restart();
    test_sleep();
    test_scan();
    test_random();
`ifdef RV32IMF_CG_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
